// File: rtl/ex_alu_pkg.sv
// Purpose: shared types and helpers for the execute-stage ALU (op codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_alu_pkg;

    localparam int DEF_W   = 32;
    localparam int ALU_OPW = 4;
    localparam int SHW     = $clog2(DEF_W);

    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // True when the op needs the iterative datapath (shift by k>0, or MUL).
    function automatic logic is_multicycle(alu_op_e op, logic [SHW-1:0] shamt);
        if (op == OP_MUL) return 1'b1;
        if (is_shift(op)) return (shamt != '0);
        return 1'b0;
    endfunction

endpackage

// File: rtl/ex_alu_seq_if.sv
// Purpose: operand/op request channel and result channel of the execute ALU.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface ex_alu_seq_if #(
    parameter int W   = 32,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] alu_op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           zero;

    // master: upstream pipeline stage plus writeback consumer
    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero
    );

    // slave: the ALU itself
    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/ex_alu_comb.sv
// Purpose: combinational single-cycle ALU ops (ADD..SLTU); any other code yields 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to sample y_o.
// Ports: a_i/b_i operands, op_i operation, y_o result.
module ex_alu_comb
    import ex_alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  alu_op_e      op_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLT:  y_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: y_o = {{(W-1){1'b0}}, (a_i < b_i)};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_seq.sv
// Purpose: execute-stage ALU; 1-cycle logic/arith, serial 1-bit-per-cycle shifts, shift-add MUL.
// Latency: 1 cycle single ops / shift k=0, k cycles for shift k>0, W cycles for MUL.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts.
// Ports: clk, rst_n (async active-low), flush (sync abort), bus (slave side of ex_alu_seq_if).
module ex_alu_seq
    import ex_alu_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int OPW = ALU_OPW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    ex_alu_seq_if.slave  bus
);

    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;   // counter must hold the value W for MUL

    state_e          state_q;
    alu_op_e         op_q;
    logic            multi_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    acc_q;       // shift value, or MUL accumulator
    logic [W-1:0]    mcand_q;     // latched A; MUL multiplicand
    logic [W-1:0]    mplier_q;    // latched B; MUL multiplier
    logic [W-1:0]    res_q;
    logic            zero_q;

    alu_op_e         op_in;
    logic [SW-1:0]   shamt_in;
    logic [CW-1:0]   cnt_load;
    logic [W-1:0]    comb_y;
    logic [W-1:0]    acc_d;
    logic [W-1:0]    res_d;

    assign op_in    = alu_op_e'(bus.alu_op);
    assign shamt_in = bus.b[SW-1:0];

    // Every op spends at least one cycle in BUSY so the result is always
    // computed from latched operands and lands one edge after accept at the earliest.
    always_comb begin
        cnt_load = CW'(1);
        if (op_in == OP_MUL)
            cnt_load = CW'(W);
        else if (is_multicycle(op_in, shamt_in))
            cnt_load = CW'(shamt_in);
    end

    ex_alu_comb #(.W(W)) u_comb (
        .a_i  (mcand_q),
        .b_i  (mplier_q),
        .op_i (op_q),
        .y_o  (comb_y)
    );

    // One iteration of the serial datapath.
    always_comb begin
        acc_d = acc_q;
        case (op_q)
            OP_SLL:  acc_d = {acc_q[W-2:0], 1'b0};
            OP_SRL:  acc_d = {1'b0, acc_q[W-1:1]};
            OP_SRA:  acc_d = {acc_q[W-1], acc_q[W-1:1]};
            OP_MUL:  acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            default: acc_d = acc_q;
        endcase
    end

    // A zero-amount shift passes A through untouched.
    always_comb begin
        res_d = comb_y;
        if (multi_q)
            res_d = acc_d;
        else if (is_shift(op_q))
            res_d = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            multi_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q     <= op_in;
                        multi_q  <= is_multicycle(op_in, shamt_in);
                        acc_q    <= (op_in == OP_MUL) ? '0 : bus.a;
                        mcand_q  <= bus.a;
                        mplier_q <= bus.b;
                        cnt_q    <= cnt_load;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (multi_q) begin
                        acc_q <= acc_d;
                        if (op_q == OP_MUL) begin
                            mcand_q  <= {mcand_q[W-2:0], 1'b0};
                            mplier_q <= {1'b0, mplier_q[W-1:1]};
                        end
                    end
                    if (cnt_q == CW'(1)) begin
                        res_q   <= res_d;
                        zero_q  <= (res_d == '0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Purpose: directed-vector bench for ex_alu_seq with hand-computed results and latencies.
// Latency: checks 1 / k / W cycle latencies from the accept edge.
// Backpressure: exercises out_ready hold, flush abort and async reset mid-op.
module tb_ex_alu_seq;
    import ex_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_alu_seq_if #(.W(32), .OPW(4)) bus ();

    ex_alu_seq #(.W(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1, then check latency, result, zero and return to IDLE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input alu_op_e op, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int c;
        c = 0;
        bus.a         = a;
        bus.b         = b;
        bus.alu_op    = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble the request side; the latched op must not notice.
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        while (!bus.out_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_lat"}, 64'(c), 64'(exp_lat));
        chk({tag, "_res"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
        @(posedge clk); #1;
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int  c;
        logic seen;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_op    = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_zero",      64'(bus.zero),      64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        run_op("add",   32'h0000000A, 32'h00000014, OP_ADD,  32'h0000001E, 1'b0, 1);
        run_op("sub",   32'h0000000A, 32'h00000014, OP_SUB,  32'hFFFFFFF6, 1'b0, 1);
        run_op("slt",   32'h0000000A, 32'h00000014, OP_SLT,  32'h00000001, 1'b0, 1);
        run_op("sltu",  32'h0000000A, 32'h00000014, OP_SLTU, 32'h00000001, 1'b0, 1);
        run_op("sltn",  32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 1'b0, 1);
        run_op("sltun", 32'hFFFFFFFF, 32'h00000001, OP_SLTU, 32'h00000000, 1'b1, 1);
        run_op("xor",   32'h00000005, 32'h00000005, OP_XOR,  32'h00000000, 1'b1, 1);
        run_op("and",   32'h0000F0F0, 32'h0000FF00, OP_AND,  32'h0000F000, 1'b0, 1);
        run_op("or",    32'h0000F0F0, 32'h0000FF00, OP_OR,   32'h0000FFF0, 1'b0, 1);
        run_op("rsvd",  32'h00000005, 32'h00000005, alu_op_e'(4'd12), 32'h00000000, 1'b1, 1);

        // Serial shifts
        run_op("sll5",   32'h00000001, 32'h00000005, OP_SLL, 32'h00000020, 1'b0, 5);
        run_op("sra4",   32'h80000000, 32'h00000004, OP_SRA, 32'hF8000000, 1'b0, 4);
        run_op("srl4",   32'h80000000, 32'h00000004, OP_SRL, 32'h08000000, 1'b0, 4);
        run_op("srl0",   32'h80000000, 32'h00000000, OP_SRL, 32'h80000000, 1'b0, 1);
        run_op("sllhi",  32'h00000003, 32'h00000021, OP_SLL, 32'h00000006, 1'b0, 1);
        run_op("sra31",  32'h80000000, 32'h0000001F, OP_SRA, 32'hFFFFFFFF, 1'b0, 31);

        // Shift-add multiply
        run_op("mul76",  32'h00000007, 32'h00000006, OP_MUL, 32'h0000002A, 1'b0, 32);
        run_op("mulneg", 32'hFFFFFFFF, 32'h00000002, OP_MUL, 32'hFFFFFFFE, 1'b0, 32);
        run_op("mul0",   32'h00000000, 32'h00000005, OP_MUL, 32'h00000000, 1'b1, 32);

        // Writeback backpressure
        bus.a = 32'd1; bus.b = 32'd2; bus.alu_op = OP_ADD;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 0;
        while (!bus.out_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp_lat", 64'(c), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_res",   64'(bus.result),    64'd3);
            chk("bp_inrdy",      64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_idle",  64'(bus.in_ready),  64'd1);

        // Flush on cycle 10 of a MUL
        bus.a = 32'd7; bus.b = 32'd6; bus.alu_op = OP_MUL; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle",  64'(bus.in_ready),  64'd1);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_res",   64'(bus.result),    64'd3);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_no_out", 64'(seen), 64'd0);

        // Async reset in the middle of a long SLL
        bus.a = 32'd1; bus.b = 32'd20; bus.alu_op = OP_SLL; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_res",   64'(bus.result),    64'd0);
        chk("arst_zero",  64'(bus.zero),      64'd0);
        chk("arst_inrdy", 64'(bus.in_ready),  64'd1);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("arst_no_out", 64'(seen), 64'd0);

        // Recovery after reset
        run_op("post_rst", 32'h12345678, 32'h11111111, OP_ADD, 32'h23456789, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
